// File: rtl/sec_time_counter.sv
// BCD MM:SS stopwatch advanced by rising edges of a synchronised 1 Hz input.
// Optional match alarm enabled by defining SEC_TIME_COUNTER_ALARM_EN.
module sec_time_counter #(
  parameter int unsigned MAX_MIN     = 59,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       clk_hz,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic       running,
  output logic       wrap,
  input  logic [7:0] alarm_min,
  input  logic [7:0] alarm_sec,
  output logic       alarm
);

  localparam logic [3:0] MAX_HI = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_LO = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tick;
  logic                   count_en;
  logic [3:0]             sec_lo_q, sec_lo_d;
  logic [3:0]             sec_hi_q, sec_hi_d;
  logic [3:0]             min_lo_q, min_lo_d;
  logic [3:0]             min_hi_q, min_hi_d;
  logic                   running_q;
  logic                   wrap_q, wrap_d;

  // clk_hz is only ever sampled; its synchronised rising edge is a count enable.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_hz};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (start_stop) begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // A tick coinciding with start_stop in RUN still counts (state_q is RUN).
  assign count_en = (state_q == RUN) & tick & ~clear;

  always_comb begin
    sec_lo_d = sec_lo_q;
    sec_hi_d = sec_hi_q;
    min_lo_d = min_lo_q;
    min_hi_d = min_hi_q;
    wrap_d   = 1'b0;
    if (clear) begin
      sec_lo_d = '0;
      sec_hi_d = '0;
      min_lo_d = '0;
      min_hi_d = '0;
    end else if (count_en) begin
      if (sec_lo_q != 4'd9) begin
        sec_lo_d = sec_lo_q + 4'd1;
      end else begin
        sec_lo_d = '0;
        if (sec_hi_q != 4'd5) begin
          sec_hi_d = sec_hi_q + 4'd1;
        end else begin
          sec_hi_d = '0;
          if (min_hi_q == MAX_HI && min_lo_q == MAX_LO) begin
            min_lo_d = '0;
            min_hi_d = '0;
            wrap_d   = 1'b1;
          end else if (min_lo_q != 4'd9) begin
            min_lo_d = min_lo_q + 4'd1;
          end else begin
            min_lo_d = '0;
            min_hi_d = min_hi_q + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sec_lo_q  <= '0;
      sec_hi_q  <= '0;
      min_lo_q  <= '0;
      min_hi_q  <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_lo_q  <= sec_lo_d;
      sec_hi_q  <= sec_hi_d;
      min_lo_q  <= min_lo_d;
      min_hi_q  <= min_hi_d;
      running_q <= (state_d == RUN);
      wrap_q    <= wrap_d;
    end
  end

  assign sec_lo  = sec_lo_q;
  assign sec_hi  = sec_hi_q;
  assign min_lo  = min_lo_q;
  assign min_hi  = min_hi_q;
  assign running = running_q;
  assign wrap    = wrap_q;

`ifdef SEC_TIME_COUNTER_ALARM_EN
  logic alarm_q, alarm_d;

  // Compared against the post-update value so the flag rises with the display.
  always_comb begin
    alarm_d = alarm_q;
    if (clear) begin
      alarm_d = 1'b0;
    end else if (count_en &&
                 {min_hi_d, min_lo_d, sec_hi_d, sec_lo_d} == {alarm_min, alarm_sec}) begin
      alarm_d = 1'b1;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) alarm_q <= 1'b0;
    else        alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`else
  logic unused_alarm_inputs;
  assign unused_alarm_inputs = ^{alarm_min, alarm_sec};
  assign alarm = 1'b0;
`endif

endmodule
